line_clear: RTL
===============

Name: line_clear

Overview:
- Downstream stage of the falling-piece mover, and sole owner of the playfield register.
- On START (mover has reported DONE), it locks the stopped piece's four cells into the board, removes every full row with gravity shift-down, then updates lines, level and score.
- It drives the board back to the mover and to the renderer.
- It uses the same START/DONE four-phase handshake as the mover.

Parameters:
- START_LEVEL, 0, value loaded into level on reset.
- ROWS, 20, playfield rows; row 0 is the top.
- COLS, 10, playfield columns; bit index equals x, 0..9.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  request to lock the current piece; held high until DONE is seen
- DONE  out  1  high while in state Done
- piece_type  in  3  type of the stopped piece
- piece_orient  in  2  orientation of the stopped piece
- piece_pos_x  in  4  pivot column
- piece_pos_y  in  5  pivot row
- LOAD_EN  in  1  preload strobe (garbage rows / debug); honoured only in Idle
- LOAD_ROW  in  5  row to preload
- LOAD_DATA  in  10  value written to bits [9:0] of that row
- board  out  32x20  playfield; bits [31:10] are always 0
- lines_total  out  32  total cleared lines
- level  out  32  current level
- score  out  32  current score
- TOP_OUT  out  1  set when row 0 is non-zero after scoring; sticky until RESET

Behaviour:
- Reset (async, while RESET is high):
  - State = Idle, board = all 0, lines_total = 0, level = START_LEVEL, score = 0.
  - lines_mod10 = 0, row pointer r = 19, clear count k = 0, TOP_OUT = 0, DONE = 0.
- Reset mid-operation aborts immediately; no partial state is retained.
- Idle:
  - LOAD_EN with LOAD_ROW < 20: board[LOAD_ROW] = {22'b0, LOAD_DATA} on the next edge.
  - LOAD_ROW >= 20 is ignored.
  - START high -> Lock. If LOAD_EN and START are high in the same cycle, the load is applied and the state still moves to Lock.
- Lock (1 cycle):
  - Sets the pivot bit plus the three cells given by the current_blocks instance.
  - Any cell with x > 9 or y > 19 is dropped.
  - Writes are OR-only, so existing bits are never cleared.
  - r = 19, k = 0, then -> Scan.
- Scan (1 cycle per row):
  - board[r][9:0] == 10'h3FF -> Shift.
  - Else if r == 0 -> Score.
  - Else r = r - 1 and stay in Scan.
- Shift (1 cycle):
  - For every i with 1 <= i <= r: board[i] = board[i-1]. board[0] = 0.
  - k = k + 1.
  - -> Scan with r unchanged, so the row is rescanned after the shift.
- Score (1 cycle):
  - lines_total += k.
  - s = lines_mod10 + k. If s >= 10: level += 1 and lines_mod10 = s - 10; else lines_mod10 = s.
  - score += B(k) * (level_old + 1), using the pre-update level. B = {0, 40, 100, 300, 1200}. Product truncated to 32 bits; the add wraps.
  - TOP_OUT |= (board[0] != 0).
  - -> Done.
- Done:
  - DONE = 1; board and counters are frozen.
  - START low -> Idle. DONE deasserts in the cycle after START is seen low.
- Latency: DONE first goes high 22 + 2k cycles after the edge that samples START in Idle.
- k is at most 4 for valid pieces; the counter is 3 bits and saturating.
- Board write sources are Lock, Shift and Idle-load only. The board is stable during Scan, Score and Done, so the mover sees a settled board when its next START begins.

Decomposition:
- Package tetris_pkg holds:
  - ROWS/COLS constants and FULL_ROW = 10'h3FF.
  - The state enum {Idle, Lock, Scan, Shift, Score, Done}.
  - The line-bonus constant array B.
  - The piece_type encoding (shared with the mover).
- Sub-module: one instance of the existing current_blocks (orientation = piece_orient, pos = piece_pos) supplies the three non-pivot cells.
- No new sub-module. Shift, scan and score logic stay in line_clear.

Test Plan:
- Reset with random prior state:
  - Expected: board all 0, score = 0, lines_total = 0, level = 0, TOP_OUT = 0, DONE = 0.
  - Assert RESET during Shift: state returns to Idle and board goes all 0 within the same cycle.
- No clear: empty board, pos (5,10).
  - Expected: exactly 4 bits set, including board[10][5]; DONE 22 cycles after START; score = 0.
- Single clear: preload row19 = 3FF, row18 = 001; lock at pos (5,2).
  - Expected: board[19] = 001; locked cells appear one row lower; lines_total = 1; score = 40; DONE at 24 cycles.
- Tetris: preload rows 16..19 = 3FF, row 15 = 200; lock at (5,2).
  - Expected: board[19] = 200; lines_total = 4; score = 1200; DONE at 30 cycles.
- Level-up boundary: reach lines_total = 9 with level 0, then clear 2 rows.
  - Expected: level = 1, lines_mod10 = 1, score gain 100 (level_old = 0).
  - Then a single clear adds 80.
- Handshake and top-out:
  - Hold START high for 10 cycles in Done: DONE stays 1.
  - LOAD_EN pulsed in Done: board unchanged.
  - START low: Idle next cycle.
  - Preload row 0 = 001 and run a no-clear lock: TOP_OUT = 1.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants, state encoding, piece codes and line bonus
package tetris_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam logic [COLS-1:0] FULL_ROW = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_SCORE,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  localparam logic [31:0] LINE_BONUS [5] = '{32'd0, 32'd40, 32'd100, 32'd300, 32'd1200};

  // Bonus for k cleared rows; counts above four are held at the four-row bonus.
  function automatic logic [31:0] line_bonus(input logic [2:0] k);
    case (k)
      3'd0:    return LINE_BONUS[0];
      3'd1:    return LINE_BONUS[1];
      3'd2:    return LINE_BONUS[2];
      3'd3:    return LINE_BONUS[3];
      default: return LINE_BONUS[4];
    endcase
  endfunction

endpackage

// File: rtl/current_blocks.sv
// rtl/current_blocks.sv - absolute coordinates of the three non-pivot cells of a piece
module current_blocks
  import tetris_pkg::*;
(
  input  logic [2:0]      piece_type_i,
  input  logic [1:0]      orient_i,
  input  logic [3:0]      pos_x_i,
  input  logic [4:0]      pos_y_i,
  output logic [2:0][5:0] blk_x_o,
  output logic [2:0][5:0] blk_y_o
);

  logic signed [2:0] bx [3];
  logic signed [2:0] by [3];
  logic signed [2:0] rx [3];
  logic signed [2:0] ry [3];

  // Orientation-0 offsets from the pivot (y grows downwards).
  always_comb begin
    bx = '{3'sd0, 3'sd0, 3'sd0};
    by = '{3'sd0, 3'sd0, 3'sd0};
    case (piece_type_i)
      PIECE_I: begin bx = '{-3'sd1, 3'sd1, 3'sd2};  by = '{3'sd0, 3'sd0, 3'sd0};    end
      PIECE_O: begin bx = '{3'sd1, 3'sd0, 3'sd1};   by = '{3'sd0, 3'sd1, 3'sd1};    end
      PIECE_T: begin bx = '{-3'sd1, 3'sd1, 3'sd0};  by = '{3'sd0, 3'sd0, -3'sd1};   end
      PIECE_S: begin bx = '{-3'sd1, 3'sd0, 3'sd1};  by = '{3'sd0, -3'sd1, -3'sd1};  end
      PIECE_Z: begin bx = '{3'sd1, 3'sd0, -3'sd1};  by = '{3'sd0, -3'sd1, -3'sd1};  end
      PIECE_J: begin bx = '{-3'sd1, 3'sd1, -3'sd1}; by = '{3'sd0, 3'sd0, -3'sd1};   end
      PIECE_L: begin bx = '{-3'sd1, 3'sd1, 3'sd1};  by = '{3'sd0, 3'sd0, -3'sd1};   end
      default: ;
    endcase
  end

  // Rotate by quarter turns and add the pivot; off-board results wrap above the legal range.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (orient_i)
        2'd0:    begin rx[i] = bx[i];  ry[i] = by[i];  end
        2'd1:    begin rx[i] = -by[i]; ry[i] = bx[i];  end
        2'd2:    begin rx[i] = -bx[i]; ry[i] = -by[i]; end
        default: begin rx[i] = by[i];  ry[i] = -bx[i]; end
      endcase
      if (piece_type_i == PIECE_O) begin
        rx[i] = bx[i];
        ry[i] = by[i];
      end
      blk_x_o[i] = {2'b00, pos_x_i} + {{3{rx[i][2]}}, rx[i]};
      blk_y_o[i] = {1'b0, pos_y_i} + {{3{ry[i][2]}}, ry[i]};
    end
  end

endmodule

// File: rtl/line_clear.sv
// rtl/line_clear.sv - locks the stopped piece, clears full rows and keeps score
module line_clear
  import tetris_pkg::*;
#(
  parameter logic [31:0] START_LEVEL = 32'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        DONE,
  input  logic [2:0]  piece_type,
  input  logic [1:0]  piece_orient,
  input  logic [3:0]  piece_pos_x,
  input  logic [4:0]  piece_pos_y,
  input  logic        LOAD_EN,
  input  logic [4:0]  LOAD_ROW,
  input  logic [9:0]  LOAD_DATA,
  output logic [31:0] board [ROWS],
  output logic [31:0] lines_total,
  output logic [31:0] level,
  output logic [31:0] score,
  output logic        TOP_OUT
);

  state_t            state_q;
  logic [COLS-1:0]   board_q [ROWS];
  logic [COLS-1:0]   lock_mask [ROWS];
  logic [31:0]       lines_q, level_q, score_q;
  logic [3:0]        mod10_q;
  logic [4:0]        r_q;
  logic [2:0]        k_q;
  logic              top_q, done_q;

  logic [2:0][5:0]   blk_x, blk_y;
  logic [5:0]        cell_x [4];
  logic [5:0]        cell_y [4];
  logic [4:0]        mod_sum_d;
  logic [31:0]       score_gain_d;

  current_blocks u_blocks (
    .piece_type_i (piece_type),
    .orient_i     (piece_orient),
    .pos_x_i      (piece_pos_x),
    .pos_y_i      (piece_pos_y),
    .blk_x_o      (blk_x),
    .blk_y_o      (blk_y)
  );

  // Per-row mask of the four piece cells that land on the board.
  always_comb begin
    cell_x[0] = {2'b00, piece_pos_x};
    cell_y[0] = {1'b0, piece_pos_y};
    for (int c = 0; c < 3; c++) begin
      cell_x[c+1] = blk_x[c];
      cell_y[c+1] = blk_y[c];
    end
    for (int r = 0; r < ROWS; r++) lock_mask[r] = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cell_y[c] == 6'(r) && cell_x[c] < 6'(COLS)) lock_mask[r][cell_x[c][3:0]] = 1'b1;
      end
    end
  end

  assign mod_sum_d    = {1'b0, mod10_q} + {2'b00, k_q};
  assign score_gain_d = line_bonus(k_q) * (level_q + 32'd1);

  // Control FSM, playfield and scoring registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      for (int r = 0; r < ROWS; r++) board_q[r] <= '0;
      lines_q <= '0;
      level_q <= START_LEVEL;
      score_q <= '0;
      mod10_q <= '0;
      r_q     <= 5'(ROWS - 1);
      k_q     <= '0;
      top_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (LOAD_EN && LOAD_ROW < 5'(ROWS)) board_q[LOAD_ROW] <= LOAD_DATA;
          if (START) state_q <= ST_LOCK;
        end
        ST_LOCK: begin
          for (int r = 0; r < ROWS; r++) board_q[r] <= board_q[r] | lock_mask[r];
          r_q     <= 5'(ROWS - 1);
          k_q     <= '0;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (board_q[r_q] == FULL_ROW) state_q <= ST_SHIFT;
          else if (r_q == 5'd0)         state_q <= ST_SCORE;
          else                          r_q     <= r_q - 5'd1;
        end
        ST_SHIFT: begin
          // Rows above the full one drop by one; r stays so the new row r is rescanned.
          for (int i = 1; i < ROWS; i++) begin
            if (5'(i) <= r_q) board_q[i] <= board_q[i-1];
          end
          board_q[0] <= '0;
          if (k_q != 3'd7) k_q <= k_q + 3'd1;
          state_q <= ST_SCAN;
        end
        ST_SCORE: begin
          lines_q <= lines_q + {29'd0, k_q};
          if (mod_sum_d >= 5'd10) begin
            level_q <= level_q + 32'd1;
            mod10_q <= 4'(mod_sum_d - 5'd10);
          end else begin
            mod10_q <= mod_sum_d[3:0];
          end
          score_q <= score_q + score_gain_d;
          top_q   <= top_q | (|board_q[0]);
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (!START) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Zero-extend rows to the 32-bit board bus.
  always_comb begin
    for (int r = 0; r < ROWS; r++) board[r] = {{(32-COLS){1'b0}}, board_q[r]};
  end

  assign DONE        = done_q;
  assign lines_total = lines_q;
  assign level       = level_q;
  assign score       = score_q;
  assign TOP_OUT     = top_q;

endmodule
